bank_axi3_mem_slave: RTL
========================

# bank_axi3_mem_slave

AXI3 responder that terminates the bank BIU's master port. It accepts AR/AW/W traffic, stores 256-bit lines in an internal word array and returns R and B responses. It serves as the memory-side endpoint for bank-level simulation and FPGA bring-up. Read and write paths are independent state machines that share one storage array.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 256, data bus width; fixed 32-byte word
- STRB_WIDTH, DATA_WIDTH/8, byte strobe width
- ID_WIDTH, 8, AXI ID width
- MEM_WORDS, 1024, number of 32-byte storage words

Ports:
- clk_i  in  1  single clock
- rst_i  in  1  asynchronous, active-high reset
- mem_axi3_arvalid_i / arready_o  in/out  1  AR handshake
- mem_axi3_arid_i  in  ID_WIDTH
- mem_axi3_araddr_i  in  ADDR_WIDTH
- mem_axi3_arlen_i  in  4
- mem_axi3_arsize_i  in  3
- mem_axi3_arburst_i  in  2
- mem_axi3_rvalid_o / rready_i  out/in  1  R handshake
- mem_axi3_rid_o  out  ID_WIDTH
- mem_axi3_rdata_o  out  DATA_WIDTH
- mem_axi3_rresp_o  out  2
- mem_axi3_rlast_o  out  1
- mem_axi3_awvalid_i / awready_o  in/out  1  AW handshake
- mem_axi3_awid_i, awaddr_i, awlen_i (4), awsize_i (3), awburst_i (2)  in
- mem_axi3_wvalid_i / wready_o  in/out  1  W handshake
- mem_axi3_wid_i  in  ID_WIDTH  ignored
- mem_axi3_wdata_i  in  DATA_WIDTH
- mem_axi3_wstrb_i  in  STRB_WIDTH
- mem_axi3_wlast_i  in  1
- mem_axi3_bvalid_o / bready_i  out/in  1  B handshake
- mem_axi3_bid_o  out  ID_WIDTH
- mem_axi3_bresp_o  out  2

## Operation
- Word index = addr[ADDR_WIDTH-1:5]; addr[4:0] ignored. Storage is not reset.
- Burst legality: size must be 3'b101. Burst must be FIXED (00, index constant) or INCR (01, index +1 per beat). Anything else is illegal. Index wraps modulo 2^(ADDR_WIDTH-5).
- Beat in range when index < MEM_WORDS.
- Read FSM R_IDLE → R_DATA:
  - R_IDLE: arready=1. On AR handshake, capture id, index, len, burst and legality, then go to R_DATA.
  - R_DATA: arready=0, rvalid=1. rdata = mem[index], or 0 if the beat is illegal or out of range. rresp = 2'b00 OKAY, or 2'b10 SLVERR for that beat. rlast=1 when beat count = len.
  - Each R handshake advances the beat. The handshake on the last beat returns to R_IDLE.
- Write FSM W_IDLE → W_DATA → W_RESP:
  - W_IDLE: awready=1. On AW handshake, capture id, index, len, burst and legality.
  - W_DATA: wready=1. Each W handshake writes byte lanes with strb=1 into mem[index]; the write is suppressed if illegal or out of range. The error flag becomes sticky on any suppressed beat. On beat count = len, go to W_RESP.
  - wlast mismatch sets the sticky error: wlast=1 before the final beat, or wlast=0 on the final beat. The beat count, not wlast, ends the burst.
  - W_RESP: bvalid=1, bid = captured id, bresp = SLVERR if sticky error, else OKAY. The B handshake returns to W_IDLE and clears the error.
- W beats arriving before the AW handshake are not accepted: wready=0 outside W_DATA.
- A read and a write to the same word in the same cycle: the read returns the pre-write data, and the write takes effect at the clock edge.

## Timing
- Reset values: arready=1, awready=1, wready=0, rvalid=0, bvalid=0, rlast=0, rdata=0, rid=0, rresp=0, bid=0, bresp=0. Both FSMs go to IDLE.
- Reset mid-burst aborts the burst. No response is issued for it.
- AR handshake at cycle t → first rvalid at t+1. With rready held 1, one beat per cycle; a len=N burst completes at t+1+N. The next arready is at t+2+N.
- R outputs hold stable while rvalid=1 and rready=0.
- AW handshake at t → wready at t+1. With wvalid held 1, the last W beat is at t+1+len and bvalid is at t+2+len. The next awready follows the cycle after the B handshake.
- bvalid holds until bready.
- Outputs are registered or decoded from state registers only. There is no combinational path from any input valid or ready to an output.

## Test plan
- Reset: assert rst_i asynchronously mid-cycle → outputs take reset values immediately; arready=awready=1.
- Single write then read: AW addr 0x40, len 0, size 5, INCR, id 0x05, W data 0xA5…A5, strb all 1 → bresp 00, bid 05. Then AR to 0x40, id 0x07 → rdata 0xA5…A5, rid 07, rlast=1, rresp 00.
- Partial strobe and INCR burst: write len 3 at 0x100 with data k per beat, then overwrite beat 1 with strb 0x0000_000F → read len 3 returns beats 0, 1 (low 4 bytes new, rest old), 2, 3. rlast only on beat 3. Insert rready stalls and check rdata stays stable.
- Errors: AR with size 3'b100 → all beats SLVERR, data 0. AW to word MEM_WORDS → bresp SLVERR and memory unchanged. AW with early wlast → SLVERR.
- Concurrency: simultaneous AR/AW to the same word in the same cycle → read returns old data, and a subsequent read returns new data.
- Backpressure: hold bready=0 for 5 cycles → bvalid held and awready=0 throughout; the next AW is accepted the cycle after the B handshake.

Source files
------------

// File: rtl/bank_axi3_mem_slave_if.sv
// ----------------------------------------------------------------------------
// bank_axi3_mem_slave_if: AXI3 AR/R/AW/W/B signal bundle, named from the slave side
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface bank_axi3_mem_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8
);
  logic                  arvalid_i;
  logic                  arready_o;
  logic [ID_WIDTH-1:0]   arid_i;
  logic [ADDR_WIDTH-1:0] araddr_i;
  logic [3:0]            arlen_i;
  logic [2:0]            arsize_i;
  logic [1:0]            arburst_i;

  logic                  rvalid_o;
  logic                  rready_i;
  logic [ID_WIDTH-1:0]   rid_o;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic [1:0]            rresp_o;
  logic                  rlast_o;

  logic                  awvalid_i;
  logic                  awready_o;
  logic [ID_WIDTH-1:0]   awid_i;
  logic [ADDR_WIDTH-1:0] awaddr_i;
  logic [3:0]            awlen_i;
  logic [2:0]            awsize_i;
  logic [1:0]            awburst_i;

  logic                  wvalid_i;
  logic                  wready_o;
  logic [ID_WIDTH-1:0]   wid_i;
  logic [DATA_WIDTH-1:0] wdata_i;
  logic [STRB_WIDTH-1:0] wstrb_i;
  logic                  wlast_i;

  logic                  bvalid_o;
  logic                  bready_i;
  logic [ID_WIDTH-1:0]   bid_o;
  logic [1:0]            bresp_o;

  modport slave (
    input  arvalid_i, arid_i, araddr_i, arlen_i, arsize_i, arburst_i,
    output arready_o,
    input  rready_i,
    output rvalid_o, rid_o, rdata_o, rresp_o, rlast_o,
    input  awvalid_i, awid_i, awaddr_i, awlen_i, awsize_i, awburst_i,
    output awready_o,
    input  wvalid_i, wid_i, wdata_i, wstrb_i, wlast_i,
    output wready_o,
    input  bready_i,
    output bvalid_o, bid_o, bresp_o
  );

  modport master (
    output arvalid_i, arid_i, araddr_i, arlen_i, arsize_i, arburst_i,
    input  arready_o,
    output rready_i,
    input  rvalid_o, rid_o, rdata_o, rresp_o, rlast_o,
    output awvalid_i, awid_i, awaddr_i, awlen_i, awsize_i, awburst_i,
    input  awready_o,
    output wvalid_i, wid_i, wdata_i, wstrb_i, wlast_i,
    input  wready_o,
    output bready_i,
    input  bvalid_o, bid_o, bresp_o
  );
endinterface

`default_nettype wire

// File: rtl/bank_axi3_mem_slave.sv
// ----------------------------------------------------------------------------
// bank_axi3_mem_slave: AXI3 memory responder, independent R/W FSMs over one array
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bank_axi3_mem_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8,
  parameter int MEM_WORDS  = 1024
) (
  input wire clk_i,
  input wire rst_i,
  bank_axi3_mem_slave_if.slave mem_axi3
);

  localparam int IDX_WIDTH = ADDR_WIDTH - 5;
  localparam int MEM_AW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [IDX_WIDTH-1:0] MEM_LIMIT = IDX_WIDTH'(MEM_WORDS);
  localparam logic [2:0] SIZE_32B    = 3'b101;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic burst_legal(input logic [2:0] size, input logic [1:0] burst);
    return (size == SIZE_32B) && ((burst == BURST_FIXED) || (burst == BURST_INCR));
  endfunction

  function automatic logic beat_ok(input logic legal, input logic [IDX_WIDTH-1:0] idx);
    return legal && (idx < MEM_LIMIT);
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

  // ---------------------------------------------------------------- read path
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;
  r_state_e r_state_q, r_state_d;

  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [IDX_WIDTH-1:0]  ridx_q, ridx_d;
  logic [3:0]            rlen_q, rlen_d;
  logic [3:0]            rcnt_q, rcnt_d;
  logic                  rincr_q, rincr_d;
  logic                  rlegal_q, rlegal_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rlast_q, rlast_d;
  logic                  ar_hs, r_hs, r_load;

  assign ar_hs = (r_state_q == R_IDLE) && mem_axi3.arvalid_i;
  assign r_hs  = (r_state_q == R_DATA) && mem_axi3.rready_i;

  always_comb begin
    r_state_d          = r_state_q;
    mem_axi3.arready_o = 1'b0;
    mem_axi3.rvalid_o  = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        mem_axi3.arready_o = 1'b1;
        if (mem_axi3.arvalid_i) r_state_d = R_DATA;
      end
      R_DATA: begin
        mem_axi3.rvalid_o = 1'b1;
        if (mem_axi3.rready_i && rlast_q) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Beat data is fetched into a register when the beat is issued, so a write
  // landing in the same cycle is not visible and stalls keep rdata stable.
  always_comb begin
    rid_d    = rid_q;
    ridx_d   = ridx_q;
    rlen_d   = rlen_q;
    rcnt_d   = rcnt_q;
    rincr_d  = rincr_q;
    rlegal_d = rlegal_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rlast_d  = rlast_q;
    r_load   = 1'b0;
    if (ar_hs) begin
      rid_d    = mem_axi3.arid_i;
      ridx_d   = mem_axi3.araddr_i[ADDR_WIDTH-1:5];
      rlen_d   = mem_axi3.arlen_i;
      rcnt_d   = 4'd0;
      rincr_d  = (mem_axi3.arburst_i == BURST_INCR);
      rlegal_d = burst_legal(mem_axi3.arsize_i, mem_axi3.arburst_i);
      r_load   = 1'b1;
    end else if (r_hs && !rlast_q) begin
      rcnt_d = rcnt_q + 4'd1;
      if (rincr_q) ridx_d = ridx_q + 1'b1;
      r_load = 1'b1;
    end
    if (r_load) begin
      rdata_d = beat_ok(rlegal_d, ridx_d) ? mem_q[ridx_d[MEM_AW-1:0]] : '0;
      rresp_d = beat_ok(rlegal_d, ridx_d) ? RESP_OKAY : RESP_SLVERR;
      rlast_d = (rcnt_d == rlen_d);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state_q <= R_IDLE;
      rid_q     <= '0;
      ridx_q    <= '0;
      rlen_q    <= '0;
      rcnt_q    <= '0;
      rincr_q   <= 1'b0;
      rlegal_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rlast_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      ridx_q    <= ridx_d;
      rlen_q    <= rlen_d;
      rcnt_q    <= rcnt_d;
      rincr_q   <= rincr_d;
      rlegal_q  <= rlegal_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
    end
  end

  assign mem_axi3.rid_o   = rid_q;
  assign mem_axi3.rdata_o = rdata_q;
  assign mem_axi3.rresp_o = rresp_q;
  assign mem_axi3.rlast_o = rlast_q;

  // --------------------------------------------------------------- write path
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
  w_state_e w_state_q, w_state_d;

  logic [ID_WIDTH-1:0]  wid_q, wid_d;
  logic [IDX_WIDTH-1:0] widx_q, widx_d;
  logic [3:0]           wlen_q, wlen_d;
  logic [3:0]           wcnt_q, wcnt_d;
  logic                 wincr_q, wincr_d;
  logic                 wlegal_q, wlegal_d;
  logic                 werr_q, werr_d;
  logic                 aw_hs, w_hs, b_hs, w_last_beat, w_ok, mem_we;

  assign aw_hs       = (w_state_q == W_IDLE) && mem_axi3.awvalid_i;
  assign w_hs        = (w_state_q == W_DATA) && mem_axi3.wvalid_i;
  assign b_hs        = (w_state_q == W_RESP) && mem_axi3.bready_i;
  assign w_last_beat = (wcnt_q == wlen_q);
  assign w_ok        = beat_ok(wlegal_q, widx_q);
  assign mem_we      = w_hs && w_ok;

  always_comb begin
    w_state_d          = w_state_q;
    mem_axi3.awready_o = 1'b0;
    mem_axi3.wready_o  = 1'b0;
    mem_axi3.bvalid_o  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        mem_axi3.awready_o = 1'b1;
        if (mem_axi3.awvalid_i) w_state_d = W_DATA;
      end
      W_DATA: begin
        mem_axi3.wready_o = 1'b1;
        if (mem_axi3.wvalid_i && w_last_beat) w_state_d = W_RESP;
      end
      W_RESP: begin
        mem_axi3.bvalid_o = 1'b1;
        if (mem_axi3.bready_i) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // The beat count terminates the burst; a disagreeing wlast only poisons bresp.
  always_comb begin
    wid_d    = wid_q;
    widx_d   = widx_q;
    wlen_d   = wlen_q;
    wcnt_d   = wcnt_q;
    wincr_d  = wincr_q;
    wlegal_d = wlegal_q;
    werr_d   = werr_q;
    if (aw_hs) begin
      wid_d    = mem_axi3.awid_i;
      widx_d   = mem_axi3.awaddr_i[ADDR_WIDTH-1:5];
      wlen_d   = mem_axi3.awlen_i;
      wcnt_d   = 4'd0;
      wincr_d  = (mem_axi3.awburst_i == BURST_INCR);
      wlegal_d = burst_legal(mem_axi3.awsize_i, mem_axi3.awburst_i);
      werr_d   = 1'b0;
    end else if (w_hs) begin
      if (!w_ok || (mem_axi3.wlast_i != w_last_beat)) werr_d = 1'b1;
      if (!w_last_beat) begin
        wcnt_d = wcnt_q + 4'd1;
        if (wincr_q) widx_d = widx_q + 1'b1;
      end
    end else if (b_hs) begin
      werr_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_state_q <= W_IDLE;
      wid_q     <= '0;
      widx_q    <= '0;
      wlen_q    <= '0;
      wcnt_q    <= '0;
      wincr_q   <= 1'b0;
      wlegal_q  <= 1'b0;
      werr_q    <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      wid_q     <= wid_d;
      widx_q    <= widx_d;
      wlen_q    <= wlen_d;
      wcnt_q    <= wcnt_d;
      wincr_q   <= wincr_d;
      wlegal_q  <= wlegal_d;
      werr_q    <= werr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (mem_axi3.wstrb_i[b]) mem_q[widx_q[MEM_AW-1:0]][b*8 +: 8] <= mem_axi3.wdata_i[b*8 +: 8];
      end
    end
  end

  assign mem_axi3.bid_o   = wid_q;
  assign mem_axi3.bresp_o = werr_q ? RESP_SLVERR : RESP_OKAY;

  logic unused_w;
  assign unused_w = &{1'b0, mem_axi3.wid_i, mem_axi3.araddr_i[4:0], mem_axi3.awaddr_i[4:0]};

endmodule

`default_nettype wire
